// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver:
// state encoding, parity modes and frame-length arithmetic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Cycles from start bit through last stop bit.
    function automatic int frame_len(input int data_width, input int parity_mode,
                                     input int stop_bits);
        return 1 + data_width + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts it
// out LSB-first as start, data, optional parity and stop bits, one bit per uart_clk.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                  uart_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done,
    output uart_state_e           dbg_state
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    uart_state_e           r_state;
    uart_state_e           w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx_out;
    logic                  w_tx_out_d;
    logic                  w_last_data;
    logic                  w_last_stop;
    logic                  w_ready;
    logic                  w_handshake;

    // Handshake: a word transfers on any rising edge where tx_valid && tx_ready;
    // ready is high in IDLE and in the final stop-bit cycle, so frames can abut.
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign w_last_stop = (r_state == STOP) && (r_bit_cnt == CNT_W'(STOP_BITS - 1));
    assign w_ready     = (r_state == IDLE) || w_last_stop;
    assign w_handshake = tx_valid && w_ready;

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx_out  <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tx_out <= w_tx_out_d;

            // Parity comes from the whole captured word, not the shifted remainder.
            if (w_handshake) begin
                r_shift  <= tx_data;
                r_parity <= (^tx_data) ^ (PARITY_MODE == PARITY_ODD);
            end else if (r_state == DATA && w_state_next == DATA) begin
                r_shift <= r_shift >> 1;
            end

            // One counter serves data bits and stop bits; it clears on every state change.
            if (w_state_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (r_state == DATA || r_state == STOP) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:   if (w_handshake) w_state_next = START;
            START:  w_state_next = DATA;
            DATA:   if (w_last_data) w_state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            PARITY: w_state_next = STOP;
            STOP:   if (w_last_stop) w_state_next = w_handshake ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The line level is chosen from the state being entered and registered,
    // so the start bit appears on the handshake edge itself.
    always_comb begin
        w_tx_out_d = 1'b1;
        tx_busy    = (r_state != IDLE);
        tx_done    = w_last_stop;
        unique case (w_state_next)
            START:   w_tx_out_d = 1'b0;
            DATA:    w_tx_out_d = (r_state == DATA) ? r_shift[1] : r_shift[0];
            PARITY:  w_tx_out_d = r_parity;
            default: w_tx_out_d = 1'b1;
        endcase
    end

    assign tx_ready  = w_ready;
    assign tx_out    = r_tx_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations, a per-cycle line
// scoreboard and a bit-serial receiver model for loopback.
module tb_uart_tx;
    import uart_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  tx_valid;
    logic [7:0]  tx_data [4];
    wire  [3:0]  w_ready;
    wire  [3:0]  w_out;
    wire  [3:0]  w_busy;
    wire  [3:0]  w_done;
    uart_state_e dbg_state [4];

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];   // {tx_out, tx_ready, tx_done, tx_busy} per cycle
    logic [7:0] word_q[$];  // words the loopback receiver should see
    logic       rx_en = 1'b0;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    uart_tx #(.DATA_WIDTH(8), .PARITY_MODE(PARITY_NONE), .STOP_BITS(1)) dut0 (
        .uart_clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(w_ready[0]), .tx_out(w_out[0]), .tx_busy(w_busy[0]),
        .tx_done(w_done[0]), .dbg_state(dbg_state[0]));
    uart_tx #(.DATA_WIDTH(8), .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1)) dut1 (
        .uart_clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(w_ready[1]), .tx_out(w_out[1]), .tx_busy(w_busy[1]),
        .tx_done(w_done[1]), .dbg_state(dbg_state[1]));
    uart_tx #(.DATA_WIDTH(8), .PARITY_MODE(PARITY_ODD), .STOP_BITS(1)) dut2 (
        .uart_clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(w_ready[2]), .tx_out(w_out[2]), .tx_busy(w_busy[2]),
        .tx_done(w_done[2]), .dbg_state(dbg_state[2]));
    uart_tx #(.DATA_WIDTH(8), .PARITY_MODE(PARITY_NONE), .STOP_BITS(2)) dut3 (
        .uart_clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(w_ready[3]), .tx_out(w_out[3]), .tx_busy(w_busy[3]),
        .tx_done(w_done[3]), .dbg_state(dbg_state[3]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("watchdog expired before the summary line");
        $fatal(1, "simulation time limit reached");
    end

    // Expected line levels for one frame, built from the UART framing rules.
    task automatic push_frame(input logic [7:0] d, input int pmode, input int stops);
        exp_q.push_back(4'b0001);
        for (int b = 0; b < 8; b++) exp_q.push_back({d[b], 3'b001});
        if (pmode == PARITY_EVEN) exp_q.push_back({^d, 3'b001});
        if (pmode == PARITY_ODD)  exp_q.push_back({~(^d), 3'b001});
        for (int s = 0; s < stops; s++) begin
            if (s == stops - 1) exp_q.push_back(4'b1111);
            else                exp_q.push_back(4'b1001);
        end
    endtask

    // Receiver model: one sample per bit cycle on the opposite clock edge.
    initial begin : rx_model
        logic [7:0] rx_word;
        logic       rx_stop;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (rx_en && !rst && w_out[0] === 1'b0) begin
                for (int b = 0; b < 8; b++) begin
                    @(negedge clk);
                    rx_word[b] = w_out[0];
                end
                @(negedge clk);
                rx_stop = w_out[0];
                checks++;
                if (word_q.size() == 0) begin
                    errors++;
                    $display("FAIL loopback_unexpected got=%h stop=%b required=no frame", rx_word, rx_stop);
                end else begin
                    want = word_q.pop_front();
                    if ({rx_stop, rx_word} !== {1'b1, want}) begin
                        errors++;
                        $display("FAIL loopback_word got=%h stop=%b required=%h stop=1", rx_word, rx_stop, want);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                obs = {w_out[i], w_ready[i], w_done[i], w_busy[i]};
                checks++;
                if (obs !== 4'b1100) begin
                    errors++;
                    $display("FAIL reset_hold dut=%0d got=%b required=1100", i, obs);
                end
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                obs = {w_out[i], w_ready[i], w_done[i], w_busy[i]};
                checks++;
                if (obs !== 4'b1100 || dbg_state[i] !== IDLE) begin
                    errors++;
                    $display("FAIL idle dut=%0d cycle=%0d got=%b state=%0d required=1100 state=0",
                             i, c, obs, dbg_state[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] obs, exp;
        @(negedge clk);
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        push_frame(8'hA5, PARITY_NONE, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tx_valid[0] = 1'b0;
            tx_data[0]  = 8'($urandom_range(0, 255));
            exp = exp_q.pop_front();
            obs = {w_out[0], w_ready[0], w_done[0], w_busy[0]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_a5 cycle=%0d got=%b required=%b", c, obs, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({w_out[0], w_busy[0], w_done[0]} !== 3'b100) begin
            errors++;
            $display("FAIL single_a5_after got=%b required=100", {w_out[0], w_busy[0], w_done[0]});
        end
    endtask

    task automatic test_parity();
        int         inst_c [3] = '{1, 2, 1};
        int         mode_c [3] = '{PARITY_EVEN, PARITY_ODD, PARITY_EVEN};
        logic [7:0] d_c    [3] = '{8'h07, 8'h07, 8'h00};
        logic       par_c  [3] = '{1'b1, 1'b0, 1'b0};
        logic [3:0] obs, exp;
        int         n;
        for (int k = 0; k < 3; k++) begin
            n = inst_c[k];
            @(negedge clk);
            tx_data[n]  = d_c[k];
            tx_valid[n] = 1'b1;
            push_frame(d_c[k], mode_c[k], 1);
            for (int c = 1; c <= frame_len(8, mode_c[k], 1); c++) begin
                @(negedge clk);
                tx_valid[n] = 1'b0;
                exp = exp_q.pop_front();
                obs = {w_out[n], w_ready[n], w_done[n], w_busy[n]};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL parity_frame case=%0d cycle=%0d got=%b required=%b", k, c, obs, exp);
                end
                if (c == 10) begin
                    checks++;
                    if (w_out[n] !== par_c[k]) begin
                        errors++;
                        $display("FAIL parity_bit case=%0d got=%b required=%b", k, w_out[n], par_c[k]);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if ({w_out[n], w_busy[n]} !== 2'b10) begin
                errors++;
                $display("FAIL parity_len case=%0d got=%b required=10", k, {w_out[n], w_busy[n]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, exp;
        int         done_n = 0;
        int         done_at [2] = '{0, 0};
        @(negedge clk);
        tx_data[3]  = 8'h55;
        tx_valid[3] = 1'b1;
        push_frame(8'h55, PARITY_NONE, 2);
        push_frame(8'h0F, PARITY_NONE, 2);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1)  tx_data[3]  = 8'h0F;
            if (c == 12) tx_valid[3] = 1'b0;
            exp = exp_q.pop_front();
            obs = {w_out[3], w_ready[3], w_done[3], w_busy[3]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b cycle=%0d got=%b required=%b", c, obs, exp);
            end
            if (w_done[3] === 1'b1) begin
                if (done_n < 2) done_at[done_n] = c;
                done_n++;
            end
        end
        checks++;
        if (done_n != 2 || done_at[1] - done_at[0] != 11) begin
            errors++;
            $display("FAIL b2b_done_spacing got=%0d pulses gap=%0d required=2 pulses gap=11",
                     done_n, done_at[1] - done_at[0]);
        end
        @(negedge clk);
        checks++;
        if ({w_out[3], w_busy[3]} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_after got=%b required=10", {w_out[3], w_busy[3]});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] obs, exp;
        @(negedge clk);
        tx_data[0]  = 8'hFF;
        tx_valid[0] = 1'b1;
        push_frame(8'hFF, PARITY_NONE, 1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tx_valid[0] = 1'b0;
            exp = exp_q.pop_front();
            obs = {w_out[0], w_ready[0], w_done[0], w_busy[0]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_pre cycle=%0d got=%b required=%b", c, obs, exp);
            end
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        obs = {w_out[0], w_ready[0], w_done[0], w_busy[0]};
        checks++;
        if (obs !== 4'b1100 || dbg_state[0] !== IDLE) begin
            errors++;
            $display("FAIL midrst_abort got=%b state=%0d required=1100 state=0", obs, dbg_state[0]);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if ({w_out[0], w_done[0]} !== 2'b10) begin
                errors++;
                $display("FAIL midrst_quiet cycle=%0d got=%b required=10", c, {w_out[0], w_done[0]});
            end
        end
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
        push_frame(8'h3C, PARITY_NONE, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tx_valid[0] = 1'b0;
            exp = exp_q.pop_front();
            obs = {w_out[0], w_ready[0], w_done[0], w_busy[0]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_3c cycle=%0d got=%b required=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [8];
        words[0] = 8'h00;
        words[1] = 8'hFF;
        words[2] = 8'h81;
        words[3] = 8'h5A;
        for (int i = 4; i < 8; i++) words[i] = 8'($urandom_range(0, 255));
        @(negedge clk);
        rx_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_data[0]  = words[i];
            tx_valid[0] = 1'b1;
            word_q.push_back(words[i]);
            @(negedge clk);
            tx_valid[0] = 1'b0;
            repeat (12) @(negedge clk);
        end
        rx_en = 1'b0;
        checks++;
        if (word_q.size() != 0) begin
            errors++;
            $display("FAIL loopback_missing got=%0d words left required=0", word_q.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = '0;
        for (int i = 0; i < 4; i++) tx_data[i] = '0;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d entries required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the counterpart to the team's UART receiver on the same serial link. It accepts a parallel word through a valid/ready handshake and serialises it LSB-first as start, data, optional parity and stop bits. It shifts one bit per uart_clk cycle, so uart_clk is the baud clock (115200 Hz). It sits between the system-side producer and the tx line pad.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
uart_clk  input  1  baud-rate clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high
tx_data  input  DATA_WIDTH  word to send; sampled only on handshake
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idles high
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-cycle pulse in the last stop-bit cycle of each frame

Behaviour:
- Reset: synchronous, active-high, one uart_clk edge. After that edge: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters and shift register cleared.
- Reset mid-frame: the frame is abandoned on the next edge, tx_out returns to 1, and no tx_done is issued.
- Handshake: a transfer occurs on an edge where tx_valid && tx_ready.
  - tx_data is captured into the shift register on that edge.
  - tx_data may change freely after the handshake.
  - When tx_valid is high, tx_data must be stable while tx_ready is low.
- tx_ready=1 in IDLE and in the final stop-bit cycle; 0 otherwise.
- States:
  - IDLE: tx_out=1. On handshake, go to START.
  - START: tx_out=0 for 1 cycle, then go to DATA.
  - DATA: tx_out=shift[0] for DATA_WIDTH cycles, shifting right each cycle; bit counter counts 0..DATA_WIDTH-1. On the last bit, go to PARITY if PARITY_MODE≠0, else go to STOP.
  - PARITY: tx_out = ^data XOR (PARITY_MODE==1) for 1 cycle. Parity is computed from the captured word, not from the shifted remainder. Then go to STOP.
  - STOP: tx_out=1 for STOP_BITS cycles. tx_done=1 in the last stop-bit cycle. On leaving STOP: handshake present → START (back-to-back, no idle gap); otherwise → IDLE.
- Latency:
  - Handshake at edge N: start bit is visible on tx_out from edge N until edge N+1.
  - tx_out is driven from a register; no combinational path from inputs to tx_out.
  - Frame length L = 1 + DATA_WIDTH + (PARITY_MODE≠0) + STOP_BITS cycles. The default is 10.
- Back-to-back streaming: with tx_valid held high, sustained throughput is exactly one frame per L cycles.
- Counters: bit counter width is $clog2(DATA_WIDTH+1). It wraps to 0 on entering START.
- Illegal or unreachable state encodings recover to IDLE with tx_out=1 on the next edge.
- tx_valid while busy (outside the final stop-bit cycle) has no effect and is held off by tx_ready=0.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams IDLE/START/DATA/PARITY/STOP; one-hot is acceptable.
  - PARITY_NONE/ODD/EVEN constants.
  - Frame-length helper function.
  - The receiver adopts the same package.
- No sub-module needed. Parity is a reduction XOR in the capture stage, and the FSM, counter and shift register form a single module.

Test Plan:
1. Reset/idle: assert rst 3 cycles, release, no tx_valid for 20 cycles → tx_out=1, tx_ready=1, tx_busy=0, tx_done never high.
2. Single byte, defaults: send 0xA5 → tx_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. tx_done high only in cycle 10; tx_ready low in cycles 1–9.
3. Parity: PARITY_MODE=2 with 0x07 → parity bit 1. PARITY_MODE=1 with 0x07 → parity bit 0. PARITY_MODE=2 with 0x00 → parity bit 0. Frame is 11 cycles.
4. Back-to-back: tx_valid held high with 0x55 then 0x0F, STOP_BITS=2 → second start bit immediately follows the second stop bit. Total 22 cycles with no extra idle; two tx_done pulses 11 cycles apart.
5. Reset mid-frame: assert rst during data bit 3 of 0xFF → tx_out=1 on the next edge, no tx_done. A subsequent 0x3C transmits correctly from a fresh start bit.
6. Loopback: drive tx_out into the team's UART receiver and send 0x00, 0xFF, 0x81, 0x5A → receiver output matches each word.
